// File: rtl/instruction_fetch_if.sv
// Fetch-side bus bundle: program-memory port, decoder strobes, PCL access and stack status.
// The fetch unit uses the master view; the decoder/memory environment uses the slave view.
interface instruction_fetch_if #(
    parameter int PC_WIDTH = 15
);
    logic [PC_WIDTH-1:0] pm_addr;
    logic [13:0]         pm_data;
    logic [13:0]         instr_current;
    logic                instr_rd_en;
    logic                instr_flush;
    logic                pc_incr_en;
    logic                pc_j_en;
    logic                pc_call_en;
    logic                pc_ret_en;
    logic                pcl_wr_en;
    logic [7:0]          pcl_wr_data;
    logic [6:0]          pclath;
    logic [7:0]          pcl_rd;
    logic                stk_ovf;
    logic                stk_unf;

    modport master (
        output pm_addr, instr_current, pcl_rd, stk_ovf, stk_unf,
        input  pm_data, instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
               pc_call_en, pc_ret_en, pcl_wr_en, pcl_wr_data, pclath
    );

    modport slave (
        input  pm_addr, instr_current, pcl_rd, stk_ovf, stk_unf,
        output pm_data, instr_rd_en, instr_flush, pc_incr_en, pc_j_en,
               pc_call_en, pc_ret_en, pcl_wr_en, pcl_wr_data, pclath
    );
endinterface

// File: rtl/instruction_fetch.sv
// PIC16-style fetch unit: program counter, current-instruction register and a circular
// hardware return stack that overwrites its oldest entry on overflow.
module instruction_fetch #(
    parameter int          PC_WIDTH    = 15,
    parameter int          STACK_DEPTH = 16,
    parameter logic [13:0] NOP_WORD    = 14'h0000
) (
    input logic               clk,
    input logic               rst,
    instruction_fetch_if.master bus
);
    localparam int SP_W    = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = SP_W + 1;
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [13:0]         instr_q, instr_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                push_en;

    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [PC_WIDTH-1:0] jump_target;
    logic [PC_WIDTH-1:0] pcl_target;
    logic [SP_W-1:0]     sp_inc;
    logic [SP_W-1:0]     sp_dec;

    assign jump_target = PC_WIDTH'({bus.pclath[6:3], instr_q[10:0]});
    assign pcl_target  = PC_WIDTH'({bus.pclath, bus.pcl_wr_data});
    assign sp_inc      = sp_q + SP_W'(1);
    assign sp_dec      = sp_q - SP_W'(1);

    // Return beats call, so a simultaneous call/return only pops.
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (bus.pc_ret_en) begin
            sp_d = sp_dec;
            pc_d = stack_q[sp_dec];
            if (depth_q == '0) unf_d = 1'b1;
            else               depth_d = depth_q - DEPTH_W'(1);
        end else if (bus.pc_call_en) begin
            push_en = 1'b1;
            sp_d    = sp_inc;
            pc_d    = jump_target;
            if (depth_q == DEPTH_FULL) ovf_d = 1'b1;
            else                       depth_d = depth_q + DEPTH_W'(1);
        end else if (bus.pc_j_en) begin
            pc_d = jump_target;
        end else if (bus.pcl_wr_en) begin
            pc_d = pcl_target;
        end else if (bus.pc_incr_en) begin
            pc_d = pc_q + PC_WIDTH'(1);
        end
    end

    always_comb begin
        instr_d = instr_q;
        if (bus.instr_flush)      instr_d = NOP_WORD;
        else if (bus.instr_rd_en) instr_d = bus.pm_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage deliberately survives reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_en && !rst) stack_q[sp_q] <= pc_q;
    end

    assign bus.pm_addr       = pc_q;
    assign bus.instr_current = instr_q;
    assign bus.pcl_rd        = pc_q[7:0];
    assign bus.stk_ovf       = ovf_q;
    assign bus.stk_unf       = unf_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, fetch, GOTO, skip, stack overflow/underflow,
// pc wrap, PCL write and reset priority over strobes.
module tb_instruction_fetch;
    logic clk;
    logic rst;
    logic nop_mode;
    int   checks;
    int   errors;

    instruction_fetch_if #(.PC_WIDTH(15)) bus ();

    instruction_fetch #(
        .PC_WIDTH    (15),
        .STACK_DEPTH (16),
        .NOP_WORD    (14'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory image: one GOTO word at 5, an address-derived pattern elsewhere.
    always_comb begin
        if (nop_mode)                 bus.pm_data = 14'h0000;
        else if (bus.pm_addr == 15'd5) bus.pm_data = 14'h2812;
        else                          bus.pm_data = bus.pm_addr[13:0] ^ 14'h3A5C;
    end

    task automatic idle_strobes();
        bus.instr_rd_en = 1'b0;
        bus.instr_flush = 1'b0;
        bus.pc_incr_en  = 1'b0;
        bus.pc_j_en     = 1'b0;
        bus.pc_call_en  = 1'b0;
        bus.pc_ret_en   = 1'b0;
        bus.pcl_wr_en   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_strobes();
    endtask

    task automatic load_pc(input logic [6:0] lath, input logic [7:0] data);
        bus.pclath      = lath;
        bus.pcl_wr_data = data;
        bus.pcl_wr_en   = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.pm_addr !== 15'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", bus.pm_addr); end
        checks++;
        if (bus.instr_current !== 14'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", bus.instr_current); end
        checks++;
        if (bus.stk_ovf !== 1'b0 || bus.stk_unf !== 1'b0) begin
            errors++; $display("FAIL reset_flags got ovf=%b unf=%b want 0 0", bus.stk_ovf, bus.stk_unf);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        nop_mode = 1'b1;
        tick();
        checks++;
        if (bus.pm_addr !== 15'h0000) begin errors++; $display("FAIL fetch_idle_addr got %h want 0000", bus.pm_addr); end
        bus.instr_rd_en = 1'b1;
        bus.pc_incr_en  = 1'b1;
        tick();
        checks++;
        if (bus.pm_addr !== 15'h0001) begin errors++; $display("FAIL fetch_pc got %h want 0001", bus.pm_addr); end
        checks++;
        if (bus.instr_current !== 14'h0000) begin errors++; $display("FAIL fetch_instr got %h want 0000", bus.instr_current); end
        tick();
        tick();
        checks++;
        if (bus.pm_addr !== 15'h0001) begin errors++; $display("FAIL fetch_hold got %h want 0001", bus.pm_addr); end
        nop_mode = 1'b0;
    endtask

    task automatic test_goto();
        load_pc(7'h00, 8'h05);
        bus.instr_rd_en = 1'b1;
        tick();
        checks++;
        if (bus.instr_current !== 14'h2812) begin errors++; $display("FAIL goto_load got %h want 2812", bus.instr_current); end
        bus.pclath      = 7'h08;
        bus.instr_flush = 1'b1;
        bus.pc_j_en     = 1'b1;
        tick();
        checks++;
        if (bus.instr_current !== 14'h0000) begin errors++; $display("FAIL goto_flush got %h want 0000", bus.instr_current); end
        checks++;
        if (bus.pm_addr !== 15'h0812) begin errors++; $display("FAIL goto_target got %h want 0812", bus.pm_addr); end
        bus.instr_rd_en = 1'b1;
        bus.pc_incr_en  = 1'b1;
        tick();
        checks++;
        if (bus.instr_current !== 14'h324E) begin errors++; $display("FAIL goto_fetch got %h want 324e", bus.instr_current); end
        checks++;
        if (bus.pm_addr !== 15'h0813) begin errors++; $display("FAIL goto_next_pc got %h want 0813", bus.pm_addr); end
    endtask

    task automatic test_skip();
        load_pc(7'h00, 8'h40);
        bus.instr_flush = 1'b1;
        bus.pc_incr_en  = 1'b1;
        tick();
        checks++;
        if (bus.instr_current !== 14'h0000 || bus.pm_addr !== 15'h0041) begin
            errors++; $display("FAIL skip_flush got instr=%h pc=%h want 0000 0041", bus.instr_current, bus.pm_addr);
        end
        bus.instr_rd_en = 1'b1;
        bus.pc_incr_en  = 1'b1;
        tick();
        checks++;
        if (bus.instr_current !== 14'h3A1D || bus.pm_addr !== 15'h0042) begin
            errors++; $display("FAIL skip_fetch got instr=%h pc=%h want 3a1d 0042", bus.instr_current, bus.pm_addr);
        end
    endtask

    task automatic test_stack();
        logic [14:0] exp_pc;
        for (int i = 0; i < 17; i++) begin
            load_pc(7'h01, 8'(i));
            bus.pc_call_en = 1'b1;
            tick();
            checks++;
            if (bus.stk_ovf !== (i == 16)) begin
                errors++; $display("FAIL call_ovf_%0d got %b want %b", i + 1, bus.stk_ovf, (i == 16));
            end
        end
        for (int k = 1; k <= 17; k++) begin
            bus.pc_ret_en = 1'b1;
            tick();
            exp_pc = (k == 1 || k == 17) ? 15'h0110 : 15'(15'h0100 + 17 - k);
            checks++;
            if (bus.pm_addr !== exp_pc) begin errors++; $display("FAIL ret_pc_%0d got %h want %h", k, bus.pm_addr, exp_pc); end
            checks++;
            if (bus.stk_unf !== (k == 17)) begin
                errors++; $display("FAIL ret_unf_%0d got %b want %b", k, bus.stk_unf, (k == 17));
            end
        end
    endtask

    task automatic test_wrap_pcl();
        load_pc(7'h7F, 8'hFF);
        checks++;
        if (bus.pm_addr !== 15'h7FFF) begin errors++; $display("FAIL pcl_max got %h want 7fff", bus.pm_addr); end
        bus.pc_incr_en = 1'b1;
        tick();
        checks++;
        if (bus.pm_addr !== 15'h0000) begin errors++; $display("FAIL pc_wrap got %h want 0000", bus.pm_addr); end
        load_pc(7'h12, 8'hA5);
        checks++;
        if (bus.pm_addr !== 15'h12A5) begin errors++; $display("FAIL pcl_write got %h want 12a5", bus.pm_addr); end
        checks++;
        if (bus.pcl_rd !== 8'hA5) begin errors++; $display("FAIL pcl_rd got %h want a5", bus.pcl_rd); end
        bus.pcl_wr_en   = 1'b1;
        bus.pc_incr_en  = 1'b1;
        bus.pcl_wr_data = 8'h10;
        tick();
        checks++;
        if (bus.pm_addr !== 15'h1210) begin errors++; $display("FAIL pcl_over_incr got %h want 1210", bus.pm_addr); end
    endtask

    task automatic test_reset_override();
        rst            = 1'b1;
        bus.pc_ret_en  = 1'b1;
        bus.pc_call_en = 1'b1;
        bus.pc_incr_en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.pm_addr !== 15'h0000 || bus.instr_current !== 14'h0000) begin
            errors++; $display("FAIL rst_override got pc=%h instr=%h want 0000 0000", bus.pm_addr, bus.instr_current);
        end
        checks++;
        if (bus.stk_ovf !== 1'b0 || bus.stk_unf !== 1'b0) begin
            errors++; $display("FAIL rst_flags got ovf=%b unf=%b want 0 0", bus.stk_ovf, bus.stk_unf);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.pm_addr !== 15'h010F) begin errors++; $display("FAIL ret_wins_pc got %h want 010f", bus.pm_addr); end
        checks++;
        if (bus.stk_unf !== 1'b1 || bus.stk_ovf !== 1'b0) begin
            errors++; $display("FAIL ret_wins_flags got ovf=%b unf=%b want 0 1", bus.stk_ovf, bus.stk_unf);
        end
        bus.pc_ret_en = 1'b1;
        tick();
        checks++;
        if (bus.pm_addr !== 15'h010E) begin errors++; $display("FAIL no_push got %h want 010e", bus.pm_addr); end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        nop_mode        = 1'b0;
        rst             = 1'b1;
        bus.pclath      = 7'h00;
        bus.pcl_wr_data = 8'h00;
        idle_strobes();
        test_reset();
        test_fetch();
        test_goto();
        test_skip();
        test_stack();
        test_wrap_pcl();
        test_reset_override();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Instruction-side counterpart of the instruction decoder. Owns the program counter, the current-instruction register and the hardware return stack.
- Acts on the decoder's strobes: instr_rd_en, instr_flush, pc_incr_en, pc_j_en, pc_call_en and pc_ret_en.
- Drives program memory and feeds instr_current back to the decoder, which reproduces PIC16F fetch/flush pipelining.

Parameters:
- PC_WIDTH, 15, program counter and program-memory address width.
- STACK_DEPTH, 16, number of return-stack entries; must be a power of 2.
- NOP_WORD, 14'h0000, word loaded into instr_current on reset and flush.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- pm_addr  output  PC_WIDTH  program-memory address; equals pc register
- pm_data  input  14  program-memory word at pm_addr; combinational read, valid in the same cycle
- instr_current  output  14  registered instruction presented to the decoder
- instr_rd_en  input  1  load pm_data into instr_current
- instr_flush  input  1  load NOP_WORD into instr_current
- pc_incr_en  input  1  pc <= pc+1
- pc_j_en  input  1  GOTO: pc <= jump target
- pc_call_en  input  1  CALL: push pc, pc <= jump target
- pc_ret_en  input  1  RETURN: pc <= popped stack entry
- pcl_wr_en  input  1  register-file write to PCL
- pcl_wr_data  input  8  data for the PCL write
- pclath  input  7  PCLATH register value
- pcl_rd  output  8  pc[7:0], for register-file reads of PCL
- stk_ovf  output  1  sticky stack-overflow flag
- stk_unf  output  1  sticky stack-underflow flag

Behaviour:
- Reset (rst high at a clk edge): pc=0, instr_current=NOP_WORD, sp=0, depth=0, stk_ovf=0, stk_unf=0. Stack contents are not cleared. Reset overrides every strobe and applies equally mid-operation.
- pc update is registered. Priority, highest first: pc_ret_en > pc_call_en > pc_j_en > pcl_wr_en > pc_incr_en. Only the highest asserted source takes effect.
- Jump target = {pclath[6:3], instr_current[10:0]}, truncated or zero-extended to PC_WIDTH.
- PCL write: pc <= {pclath[6:0], pcl_wr_data}, truncated to PC_WIDTH.
- Increment: pc <= pc+1 modulo 2^PC_WIDTH. The all-ones pc wraps to 0.
- instr_current update is registered. instr_flush beats instr_rd_en. If neither is asserted, the register holds.
- instr_rd_en captures pm_data at the pre-edge pc. With simultaneous instr_rd_en and pc_incr_en, the word at pc is loaded and pc advances to pc+1.
- Resulting sequences:
  - GOTO (flush + j): instr_current=NOP, pc=target. The next rd+incr loads word[target] and sets pc=target+1. This gives the two-cycle branch.
  - Skip (flush + incr): instr_current=NOP, pc=pc+1, so the word at the old pc is discarded.
- Call: stack[sp] <= pc (the return address, since pc already points past the CALL); sp <= sp+1 mod STACK_DEPTH; pc <= jump target.
  - If depth==STACK_DEPTH: the oldest entry is overwritten, stk_ovf<=1, depth stays at STACK_DEPTH. Otherwise depth+1.
- Return: sp <= sp-1 mod STACK_DEPTH; pc <= stack[sp-1].
  - If depth==0: stk_unf<=1, the wrapped entry is still loaded, depth stays 0. Otherwise depth-1.
- Simultaneous call and return: return wins. No push occurs and the stack is unchanged except for the pop.
- stk_ovf and stk_unf clear only on rst.
- pm_addr and pcl_rd are combinational from the pc register. There is no added latency.

Test Plan:
- Reset, then 4 cycles of pm_data=NOP with rd+incr asserted in one cycle -> pc=1, instr_current=14'h0000. pm_addr tracks 0 then 1.
- pm[5]=14'h2812 (GOTO 0x012), pclath=7'h08; assert flush+j with instr_current=14'h2812 -> instr_current=0, pc=15'h0812. The next rd+incr loads pm[0x812] and sets pc=15'h0813.
- pc=15'h0040; assert flush+incr -> instr_current=NOP, pc=15'h0041. Then rd+incr -> pm[0x41] loaded, pc=15'h0042 (word at 0x40 is skipped).
- 17 calls from pc values 0x100..0x110, then 17 returns -> stk_ovf=1 after call 17. Returns yield 0x110, 0x10F, ..., 0x101, then 0x110 again, with stk_unf=1 on the 17th return.
- pc=15'h7FFF, pc_incr_en -> pc=0. pcl_wr_en with data 8'hA5, pclath=7'h12 -> pc=15'h12A5, pcl_rd=8'hA5.
- Assert pc_ret_en, pc_call_en and pc_incr_en together with rst high -> all reset values hold. Then the same strobes with rst low -> only the return takes effect.
